// File: rtl/id_issue_ctrl.sv
// Decode/issue control: register file with write-through bypass, load-use
// hazard detection, and a two-state FSM that holds issue for multi-cycle MUL.
module id_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_i,
    input  logic        instr_valid_i,
    input  logic [3:0]  ex_opcode_i,
    input  logic [2:0]  ex_rd_i,
    input  logic        wb_we_i,
    input  logic [2:0]  wb_rd_i,
    input  logic [7:0]  wb_data_i,
    output logic [3:0]  opcode_o,
    output logic [7:0]  a_o,
    output logic [7:0]  b_o,
    output logic [2:0]  rs_o,
    output logic [2:0]  rt_o,
    output logic [2:0]  rd_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic [15:0] stall_cnt_o
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MUL_BUSY = 1'b1;
    localparam logic [3:0] OP_LOAD  = 4'hA;
    localparam logic [3:0] OP_MUL   = 4'hC;

    logic [0:0]  state_q, state_d;
    logic [1:0]  mul_cnt_q, mul_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  rf_q [8];

    logic [3:0]  op;
    logic [2:0]  rs, rt, rd;
    logic        wb_hit;
    logic        rt_used;
    logic        load_use;
    logic        busy;
    logic        stall;

    // A bubble decodes as all-zero fields, so operands fall back to r0.
    assign op = instr_valid_i ? instr_i[15:12] : 4'h0;
    assign rd = instr_valid_i ? instr_i[11:9]  : 3'd0;
    assign rs = instr_valid_i ? instr_i[8:6]   : 3'd0;
    assign rt = instr_valid_i ? instr_i[5:3]   : 3'd0;

    assign wb_hit = wb_we_i && (wb_rd_i != 3'd0);

    always_comb begin
        a_o = 8'h00;
        b_o = 8'h00;
        if (rs != 3'd0) begin
            a_o = (wb_hit && wb_rd_i == rs) ? wb_data_i : rf_q[rs];
        end
        if (rt != 3'd0) begin
            b_o = (wb_hit && wb_rd_i == rt) ? wb_data_i : rf_q[rt];
        end
    end

    // LOAD only reads rs; every other opcode is treated as reading both sources.
    assign rt_used  = (op != OP_LOAD);
    assign load_use = (ex_opcode_i == OP_LOAD) && (ex_rd_i != 3'd0) && instr_valid_i &&
                      ((ex_rd_i == rs) || (rt_used && (ex_rd_i == rt)));
    assign busy     = (state_q == MUL_BUSY);
    assign stall    = busy || load_use;

    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        case (state_q)
            IDLE: begin
                if (instr_valid_i && (op == OP_MUL) && !load_use) begin
                    state_d   = MUL_BUSY;
                    mul_cnt_d = 2'd2;
                end
            end
            MUL_BUSY: begin
                mul_cnt_d = mul_cnt_q - 2'd1;
                if (mul_cnt_q == 2'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mul_cnt_d = 2'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mul_cnt_q   <= 2'd0;
            stall_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            mul_cnt_q   <= mul_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset wins over a same-edge writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 8'h00;
            end
        end else if (wb_hit) begin
            rf_q[wb_rd_i] <= wb_data_i;
        end
    end

    assign opcode_o    = op;
    assign rs_o        = rs;
    assign rt_o        = rt;
    assign rd_o        = rd;
    assign stall_o     = stall;
    assign flush_o     = stall;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: regfile/bypass, load-use, MUL FSM,
// reset abort and stall counter saturation.
module tb_id_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_i;
    logic        instr_valid_i;
    logic [3:0]  ex_opcode_i;
    logic [2:0]  ex_rd_i;
    logic        wb_we_i;
    logic [2:0]  wb_rd_i;
    logic [7:0]  wb_data_i;
    logic [3:0]  opcode_o;
    logic [7:0]  a_o, b_o;
    logic [2:0]  rs_o, rt_o, rd_o;
    logic        stall_o, flush_o;
    logic [15:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_issue_ctrl dut (
        .clk(clk), .rst(rst), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .ex_opcode_i(ex_opcode_i), .ex_rd_i(ex_rd_i), .wb_we_i(wb_we_i),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .opcode_o(opcode_o),
        .a_o(a_o), .b_o(b_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o),
        .stall_o(stall_o), .flush_o(flush_o), .stall_cnt_o(stall_cnt_o)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic v);
        instr_i       = {op, rd, rs, rt, 3'b101};
        instr_valid_i = v;
    endtask

    task automatic wb(input logic we, input logic [2:0] rd, input logic [7:0] d);
        wb_we_i   = we;
        wb_rd_i   = rd;
        wb_data_i = d;
    endtask

    task automatic ex(input logic [3:0] op, input logic [2:0] rd);
        ex_opcode_i = op;
        ex_rd_i     = rd;
    endtask

    // Advance past the next rising edge so new inputs are applied mid-cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        issue(4'h0, 3'd0, 3'd0, 3'd0, 1'b0);
        ex(4'h0, 3'd0);
        wb(1'b1, 3'd3, 8'h77);
        repeat (2) next_cycle();

        // Reset released; writeback during reset must have been dropped.
        rst = 1'b0;
        wb(1'b0, 3'd0, 8'h00);
        issue(4'h1, 3'd1, 3'd3, 3'd0, 1'b1);
        #1;
        chk("rst_stall_cnt", stall_cnt_o, 16'h0000);
        chk("rst_stall", {15'd0, stall_o}, 16'd0);
        chk("rst_wb_dropped_r3", {8'd0, a_o}, 16'h0000);

        next_cycle();
        issue(4'h0, 3'd0, 3'd0, 3'd0, 1'b0);
        wb(1'b1, 3'd3, 8'h5A);
        next_cycle();
        wb(1'b0, 3'd0, 8'h00);
        issue(4'h1, 3'd1, 3'd3, 3'd0, 1'b1);
        #1;
        chk("wr_rd_a", {8'd0, a_o}, 16'h005A);
        chk("wr_rd_b", {8'd0, b_o}, 16'h0000);
        chk("wr_rd_stall", {15'd0, stall_o}, 16'd0);
        chk("wr_rd_opcode", {12'd0, opcode_o}, 16'h0001);
        chk("wr_rd_fields", {7'd0, rd_o, rs_o, rt_o}, {7'd0, 3'd1, 3'd3, 3'd0});

        next_cycle();
        wb(1'b1, 3'd2, 8'h33);
        issue(4'h2, 3'd4, 3'd2, 3'd3, 1'b1);
        #1;
        chk("bypass_a", {8'd0, a_o}, 16'h0033);
        chk("bypass_b_regfile", {8'd0, b_o}, 16'h005A);

        next_cycle();
        wb(1'b1, 3'd0, 8'hFF);
        issue(4'h3, 3'd4, 3'd0, 3'd2, 1'b1);
        #1;
        chk("r0_no_bypass", {8'd0, a_o}, 16'h0000);
        chk("r2_written", {8'd0, b_o}, 16'h0033);

        next_cycle();
        wb(1'b0, 3'd0, 8'h00);
        issue(4'h4, 3'd4, 3'd0, 3'd0, 1'b1);
        #1;
        chk("r0_reads_zero", {8'd0, a_o}, 16'h0000);

        next_cycle();
        issue(4'h2, 3'd7, 3'd3, 3'd2, 1'b0);
        #1;
        chk("bubble_opcode", {12'd0, opcode_o}, 16'h0000);
        chk("bubble_fields", {7'd0, rd_o, rs_o, rt_o}, 16'h0000);
        chk("bubble_a", {8'd0, a_o}, 16'h0000);

        // Load-use on rt.
        next_cycle();
        ex(4'hA, 3'd4);
        issue(4'h2, 3'd1, 3'd1, 3'd4, 1'b1);
        #1;
        chk("lu_stall", {15'd0, stall_o}, 16'd1);
        chk("lu_flush", {15'd0, flush_o}, 16'd1);

        next_cycle();
        ex(4'h0, 3'd0);
        #1;
        chk("lu_resolved", {15'd0, stall_o}, 16'd0);
        chk("lu_cnt", stall_cnt_o, 16'd1);

        next_cycle();
        ex(4'hA, 3'd0);
        issue(4'h2, 3'd1, 3'd0, 3'd0, 1'b1);
        #1;
        chk("lu_rd0_nostall", {15'd0, stall_o}, 16'd0);

        next_cycle();
        ex(4'hA, 3'd4);
        issue(4'hA, 3'd1, 3'd2, 3'd4, 1'b1);
        #1;
        chk("lu_load_rt_unused", {15'd0, stall_o}, 16'd0);

        // Plain MUL: one issue cycle then two stall cycles.
        next_cycle();
        ex(4'h0, 3'd0);
        issue(4'hC, 3'd5, 3'd1, 3'd2, 1'b1);
        #1;
        chk("mul_issue_stall", {15'd0, stall_o}, 16'd0);
        chk("mul_opcode", {12'd0, opcode_o}, 16'h000C);
        next_cycle();
        issue(4'h1, 3'd6, 3'd3, 3'd2, 1'b1);
        #1;
        chk("mul_busy1", {14'd0, stall_o, flush_o}, 16'd3);
        next_cycle();
        #1;
        chk("mul_busy2", {14'd0, stall_o, flush_o}, 16'd3);
        next_cycle();
        #1;
        chk("mul_done", {14'd0, stall_o, flush_o}, 16'd0);
        chk("mul_cnt", stall_cnt_o, 16'd3);

        // MUL behind a load-use hazard on rs.
        next_cycle();
        ex(4'hA, 3'd1);
        issue(4'hC, 3'd5, 3'd1, 3'd2, 1'b1);
        #1;
        chk("prio_hazard", {15'd0, stall_o}, 16'd1);
        next_cycle();
        ex(4'h0, 3'd0);
        #1;
        chk("prio_mul_issue", {15'd0, stall_o}, 16'd0);
        next_cycle();
        issue(4'h1, 3'd6, 3'd3, 3'd2, 1'b1);
        #1;
        chk("prio_busy1", {15'd0, stall_o}, 16'd1);
        next_cycle();
        #1;
        chk("prio_busy2", {15'd0, stall_o}, 16'd1);
        next_cycle();
        #1;
        chk("prio_done", {15'd0, stall_o}, 16'd0);
        chk("prio_cnt", stall_cnt_o, 16'd6);

        // Reset during MUL_BUSY.
        issue(4'hC, 3'd5, 3'd1, 3'd2, 1'b1);
        next_cycle();
        issue(4'h1, 3'd6, 3'd3, 3'd2, 1'b1);
        #1;
        chk("rmul_busy", {15'd0, stall_o}, 16'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        chk("rmul_stall", {15'd0, stall_o}, 16'd0);
        chk("rmul_cnt", stall_cnt_o, 16'd0);
        chk("rmul_rf", {a_o, b_o}, 16'h0000);
        next_cycle();
        #1;
        chk("rmul_idle", {15'd0, stall_o}, 16'd0);

        // Saturation: 65540 continuous hazard stalls.
        ex(4'hA, 3'd1);
        issue(4'h1, 3'd2, 3'd1, 3'd0, 1'b1);
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_cnt", stall_cnt_o, 16'hFFFF);
        next_cycle();
        chk("sat_hold", stall_cnt_o, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
